dmem_port_arbiter: RTL and testbench

Sequences the single-port data RAM and shares it between two requesters: the decode-stage load read (mem_rd_req/mem_rd_addr) and the execute-stage store write.
- Picks one request at a time and drives the RAM port for one cycle.
- For a read, waits a fixed RAM latency, then returns the data with a valid pulse.
- Raises hold_o so pipeline control can stall the core while an access is pending.

---
 rtl/dmem_port_arbiter_if.sv | 40 ++++
 rtl/dmem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Request/grant and RAM-port bundle for dmem_port_arbiter.
// The arbiter takes the slave modport; requesters and the RAM model take master.
interface dmem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  // Handshake: a requester raises req with stable addr/data/strb and holds it
  // until the one-cycle gnt pulse, then drops req the following cycle. A read
  // result arrives later as a one-cycle rd_valid_o pulse; a write is complete
  // in the same cycle as its gnt (wr_done_o).
  logic               rd_req_i;
  logic [WIDTH-1:0]   rd_addr_i;
  logic               rd_gnt_o;
  logic [WIDTH-1:0]   rd_data_o;
  logic               rd_valid_o;
  logic               wr_req_i;
  logic [WIDTH-1:0]   wr_addr_i;
  logic [WIDTH-1:0]   wr_data_i;
  logic [WIDTH/8-1:0] wr_strb_i;
  logic               wr_gnt_o;
  logic               wr_done_o;
  logic               ram_en_o;
  logic               ram_we_o;
  logic [WIDTH-1:0]   ram_addr_o;
  logic [WIDTH-1:0]   ram_wdata_o;
  logic [WIDTH/8-1:0] ram_wstrb_o;
  logic [WIDTH-1:0]   ram_rdata_i;
  logic               hold_o;

  modport slave (
    input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, wr_strb_i, ram_rdata_i,
    output rd_gnt_o, rd_data_o, rd_valid_o, wr_gnt_o, wr_done_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wstrb_o, hold_o
  );

  modport master (
    output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, wr_strb_i, ram_rdata_i,
    input  rd_gnt_o, rd_data_o, rd_valid_o, wr_gnt_o, wr_done_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wstrb_o, hold_o
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data RAM between the load read and the store write.
// Optional macro DMEM_ARB_RR_EN: alternate the grant on a read/write tie.
module dmem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int RAM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_port_arbiter_if.slave   bus,
  output logic [1:0]           state_dbg
);
  localparam int SW = WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR       = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [SW-1:0]    wstrb_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             grant_wr;
  logic             grant_rd;

`ifdef DMEM_ARB_RR_EN
  // 0 = read granted last, 1 = write granted last; reset value favours the write.
  logic last_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr <= 1'b0;
    end else if (grant_wr) begin
      last_wr <= 1'b1;
    end else if (grant_rd) begin
      last_wr <= 1'b0;
    end
  end

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE) begin
      if (bus.wr_req_i && bus.rd_req_i) begin
        grant_wr = !last_wr;
        grant_rd = last_wr;
      end else begin
        grant_wr = bus.wr_req_i;
        grant_rd = bus.rd_req_i;
      end
    end
  end
`else
  always_comb begin
    grant_wr = (state == IDLE) && bus.wr_req_i;
    grant_rd = (state == IDLE) && bus.rd_req_i && !bus.wr_req_i;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_wr) begin
          state_nxt = WR;
        end else if (grant_rd) begin
          state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  if (cnt == 3'd1) state_nxt = IDLE;
      WR:       state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_valid_q <= 1'b0;
      if (grant_wr) begin
        addr_q  <= bus.wr_addr_i;
        wdata_q <= bus.wr_data_i;
        wstrb_q <= bus.wr_strb_i;
      end else if (grant_rd) begin
        addr_q  <= bus.rd_addr_i;
      end
      // RAM data is valid in the last counted wait cycle; capture it there.
      if (state == RD_ISSUE) begin
        cnt <= 3'(RAM_LAT);
      end else if (state == RD_WAIT) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          rd_data_q  <= bus.ram_rdata_i;
          rd_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ram_en_o    = (state == WR) || (state == RD_ISSUE);
  assign bus.ram_we_o    = (state == WR);
  assign bus.ram_addr_o  = bus.ram_en_o ? addr_q : '0;
  assign bus.ram_wdata_o = (state == WR) ? wdata_q : '0;
  assign bus.ram_wstrb_o = (state == WR) ? wstrb_q : '0;
  assign bus.rd_gnt_o    = (state == RD_ISSUE);
  assign bus.wr_gnt_o    = (state == WR);
  assign bus.wr_done_o   = (state == WR);
  assign bus.rd_data_o   = rd_data_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.hold_o      = (state != IDLE) || bus.rd_req_i || bus.wr_req_i;
  assign state_dbg       = state;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: one instance with RAM_LAT=1, one with RAM_LAT=3.
// Cycle c is the interval after the c-th rising edge of a scenario; inputs change at edge+1, outputs are sampled at the falling edge.
module tb_dmem_port_arbiter;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] st1, st3;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.WIDTH(W)) b1 ();
  dmem_port_arbiter_if #(.WIDTH(W)) b3 ();

  dmem_port_arbiter #(.WIDTH(W), .RAM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1), .state_dbg(st1));
  dmem_port_arbiter #(.WIDTH(W), .RAM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3), .state_dbg(st3));

  // RAM contents: one fixed word, everything else derived from the address.
  function automatic logic [W-1:0] rd_for(input logic [W-1:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // RAM models: data appears RAM_LAT cycles after the enable cycle, zero otherwise.
  logic [W-1:0] p3_a, p3_b;
  always @(posedge clk) begin
    b1.ram_rdata_i <= (b1.ram_en_o && !b1.ram_we_o) ? rd_for(b1.ram_addr_o) : '0;
    p3_a           <= (b3.ram_en_o && !b3.ram_we_o) ? rd_for(b3.ram_addr_o) : '0;
    p3_b           <= p3_a;
    b3.ram_rdata_i <= p3_b;
  end

  // The RAM strobe must never be high in two consecutive cycles.
  logic prev_en1 = 1'b0, prev_en3 = 1'b0;
  always @(negedge clk) begin
    if (b1.ram_en_o) begin
      n_cmp++;
      if (prev_en1) begin
        n_bad++;
        $display("FAIL en_gap1 t=%0t: ram_en_o high in consecutive cycles, required a gap", $time);
      end
    end
    if (b3.ram_en_o) begin
      n_cmp++;
      if (prev_en3) begin
        n_bad++;
        $display("FAIL en_gap3 t=%0t: ram_en_o high in consecutive cycles, required a gap", $time);
      end
    end
    prev_en1 = b1.ram_en_o;
    prev_en3 = b3.ram_en_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    @(negedge clk);
    n_cmp++;
    if ({b1.ram_en_o, b1.ram_we_o, b1.ram_addr_o, b1.ram_wdata_o, b1.ram_wstrb_o, b1.rd_gnt_o,
         b1.rd_data_o, b1.rd_valid_o, b1.wr_gnt_o, b1.wr_done_o, b1.hold_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_out1: outputs not all zero (en=%b gnt=%b data=%h hold=%b)",
               b1.ram_en_o, b1.rd_gnt_o, b1.rd_data_o, b1.hold_o);
    end
    n_cmp++;
    if ({b3.ram_en_o, b3.ram_we_o, b3.ram_addr_o, b3.ram_wdata_o, b3.ram_wstrb_o, b3.rd_gnt_o,
         b3.rd_data_o, b3.rd_valid_o, b3.wr_gnt_o, b3.wr_done_o, b3.hold_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_out3: outputs not all zero (en=%b gnt=%b data=%h hold=%b)",
               b3.ram_en_o, b3.rd_gnt_o, b3.rd_data_o, b3.hold_o);
    end
    n_cmp++;
    if (st1 !== 2'd0 || st3 !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d/%0d, required 0/0 (IDLE)", st1, st3);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_read();
    b1.rd_req_i  = 1'b1;
    b1.rd_addr_i = 32'h0000_0100;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) b1.rd_req_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (b1.ram_en_o !== (c == 1) || b1.rd_gnt_o !== (c == 1) || b1.ram_we_o !== 1'b0) begin
        n_bad++;
        $display("FAIL read_issue c=%0d: en=%b gnt=%b we=%b, required en=gnt=%b we=0",
                 c, b1.ram_en_o, b1.rd_gnt_o, b1.ram_we_o, c == 1);
      end
      if (c == 1) begin
        n_cmp++;
        if (b1.ram_addr_o !== 32'h0000_0100) begin
          n_bad++;
          $display("FAIL read_addr: got %h, required 00000100", b1.ram_addr_o);
        end
      end
      n_cmp++;
      if (b1.rd_valid_o !== (c == 3) || b1.hold_o !== (c < 3)) begin
        n_bad++;
        $display("FAIL read_valid_hold c=%0d: valid=%b hold=%b, required valid=%b hold=%b",
                 c, b1.rd_valid_o, b1.hold_o, c == 3, c < 3);
      end
      if (c == 3) begin
        n_cmp++;
        if (b1.rd_data_o !== 32'hDEAD_BEEF) begin
          n_bad++;
          $display("FAIL read_data: got %h, required deadbeef", b1.rd_data_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_write();
    b1.wr_req_i  = 1'b1;
    b1.wr_addr_i = 32'h0000_0104;
    b1.wr_data_i = 32'h1234_5678;
    b1.wr_strb_i = 4'hF;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) b1.wr_req_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (b1.ram_en_o !== (c == 1) || b1.ram_we_o !== (c == 1) || b1.wr_gnt_o !== (c == 1) ||
          b1.wr_done_o !== (c == 1) || b1.hold_o !== (c < 2)) begin
        n_bad++;
        $display("FAIL write_ctrl c=%0d: en=%b we=%b gnt=%b done=%b hold=%b, required %b %b %b %b %b",
                 c, b1.ram_en_o, b1.ram_we_o, b1.wr_gnt_o, b1.wr_done_o, b1.hold_o,
                 c == 1, c == 1, c == 1, c == 1, c < 2);
      end
      if (c == 1) begin
        n_cmp++;
        if (b1.ram_addr_o !== 32'h0000_0104 || b1.ram_wdata_o !== 32'h1234_5678 || b1.ram_wstrb_o !== 4'hF) begin
          n_bad++;
          $display("FAIL write_bus: addr=%h data=%h strb=%h, required 00000104 12345678 f",
                   b1.ram_addr_o, b1.ram_wdata_o, b1.ram_wstrb_o);
        end
      end
      tick();
    end
  endtask

  // Tie right after a completed write: fixed priority serves the write first,
  // alternation serves the read first.
  task automatic test_tie();
    int trd, twr;
`ifdef DMEM_ARB_RR_EN
    trd = 1;
    twr = 4;
`else
    twr = 1;
    trd = 3;
`endif
    b1.rd_req_i  = 1'b1;
    b1.rd_addr_i = 32'h0000_0200;
    b1.wr_req_i  = 1'b1;
    b1.wr_addr_i = 32'h0000_0204;
    b1.wr_data_i = 32'hCAFE_F00D;
    b1.wr_strb_i = 4'h3;
    for (int c = 0; c < 7; c++) begin
      if (c == twr + 1) b1.wr_req_i = 1'b0;
      if (c == trd + 1) b1.rd_req_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (b1.ram_en_o !== (c == trd || c == twr) || b1.ram_we_o !== (c == twr) ||
          b1.wr_gnt_o !== (c == twr) || b1.rd_gnt_o !== (c == trd)) begin
        n_bad++;
        $display("FAIL tie_order c=%0d: en=%b we=%b wr_gnt=%b rd_gnt=%b, required %b %b %b %b",
                 c, b1.ram_en_o, b1.ram_we_o, b1.wr_gnt_o, b1.rd_gnt_o,
                 c == trd || c == twr, c == twr, c == twr, c == trd);
      end
      if (c == twr || c == trd) begin
        n_cmp++;
        if (b1.ram_addr_o !== ((c == twr) ? 32'h0000_0204 : 32'h0000_0200)) begin
          n_bad++;
          $display("FAIL tie_addr c=%0d: got %h, required %h", c, b1.ram_addr_o,
                   (c == twr) ? 32'h0000_0204 : 32'h0000_0200);
        end
      end
      n_cmp++;
      if (b1.rd_valid_o !== (c == trd + 2) || b1.hold_o !== (c <= 4)) begin
        n_bad++;
        $display("FAIL tie_valid_hold c=%0d: valid=%b hold=%b, required valid=%b hold=%b",
                 c, b1.rd_valid_o, b1.hold_o, c == trd + 2, c <= 4);
      end
      if (c == trd + 2) begin
        n_cmp++;
        if (b1.rd_data_o !== 32'h0200_FDFF) begin
          n_bad++;
          $display("FAIL tie_data: got %h, required 0200fdff", b1.rd_data_o);
        end
      end
      tick();
    end
  endtask

  // A read raised while a write is in progress is only seen once IDLE resumes.
  task automatic test_back_to_back();
    b1.wr_req_i  = 1'b1;
    b1.wr_addr_i = 32'h0000_0500;
    b1.wr_data_i = 32'h1111_2222;
    b1.wr_strb_i = 4'hC;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin
        b1.rd_req_i  = 1'b1;
        b1.rd_addr_i = 32'h0000_0504;
      end
      if (c == 2) b1.wr_req_i = 1'b0;
      if (c == 4) b1.rd_req_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (b1.ram_en_o !== (c == 1 || c == 3) || b1.ram_we_o !== (c == 1) || b1.rd_gnt_o !== (c == 3)) begin
        n_bad++;
        $display("FAIL b2b_issue c=%0d: en=%b we=%b rd_gnt=%b, required %b %b %b",
                 c, b1.ram_en_o, b1.ram_we_o, b1.rd_gnt_o, c == 1 || c == 3, c == 1, c == 3);
      end
      if (c == 1) begin
        n_cmp++;
        if (b1.ram_wstrb_o !== 4'hC || b1.ram_wdata_o !== 32'h1111_2222) begin
          n_bad++;
          $display("FAIL b2b_wbus: strb=%h data=%h, required c 11112222", b1.ram_wstrb_o, b1.ram_wdata_o);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (b1.rd_valid_o !== 1'b1 || b1.rd_data_o !== 32'h0504_FAFB) begin
          n_bad++;
          $display("FAIL b2b_rdata: valid=%b data=%h, required 1 0504fafb", b1.rd_valid_o, b1.rd_data_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_lat3();
    b3.rd_req_i  = 1'b1;
    b3.rd_addr_i = 32'h0000_0300;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) b3.rd_req_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (b3.ram_en_o !== (c == 1) || b3.rd_valid_o !== (c == 5) || b3.hold_o !== (c <= 4)) begin
        n_bad++;
        $display("FAIL lat3 c=%0d: en=%b valid=%b hold=%b, required %b %b %b",
                 c, b3.ram_en_o, b3.rd_valid_o, b3.hold_o, c == 1, c == 5, c <= 4);
      end
      if (c == 5) begin
        n_cmp++;
        if (b3.rd_data_o !== 32'h0300_FCFF) begin
          n_bad++;
          $display("FAIL lat3_data: got %h, required 0300fcff", b3.rd_data_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_in_wait();
    b3.rd_req_i  = 1'b1;
    b3.rd_addr_i = 32'h0000_0310;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) b3.rd_req_i = 1'b0;
      if (c == 3) rst = 1'b1;
      if (c == 4) rst = 1'b0;
      @(negedge clk);
      if (c == 3) begin
        n_cmp++;
        if (st3 !== 2'd2) begin
          n_bad++;
          $display("FAIL rstwait_pre: state=%0d, required 2 (RD_WAIT)", st3);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if ({b3.ram_en_o, b3.ram_we_o, b3.ram_addr_o, b3.rd_gnt_o, b3.rd_data_o, b3.rd_valid_o,
             b3.wr_gnt_o, b3.wr_done_o, b3.hold_o} !== '0 || st3 !== 2'd0) begin
          n_bad++;
          $display("FAIL rstwait_out: state=%0d data=%h valid=%b hold=%b, required all zero",
                   st3, b3.rd_data_o, b3.rd_valid_o, b3.hold_o);
        end
      end
      if (c >= 5) begin
        n_cmp++;
        if (b3.rd_valid_o !== 1'b0) begin
          n_bad++;
          $display("FAIL rstwait_novalid c=%0d: valid=%b, required 0", c, b3.rd_valid_o);
        end
      end
      tick();
    end
    // A fresh read after the reset completes with normal latency.
    b3.rd_req_i  = 1'b1;
    b3.rd_addr_i = 32'h0000_0320;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) b3.rd_req_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (b3.ram_en_o !== (c == 1) || b3.rd_valid_o !== (c == 5)) begin
        n_bad++;
        $display("FAIL rstwait_next c=%0d: en=%b valid=%b, required %b %b",
                 c, b3.ram_en_o, b3.rd_valid_o, c == 1, c == 5);
      end
      if (c == 5) begin
        n_cmp++;
        if (b3.rd_data_o !== 32'h0320_FCDF) begin
          n_bad++;
          $display("FAIL rstwait_data: got %h, required 0320fcdf", b3.rd_data_o);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst          = 1'b1;
    b1.rd_req_i  = 1'b0;
    b1.rd_addr_i = '0;
    b1.wr_req_i  = 1'b0;
    b1.wr_addr_i = '0;
    b1.wr_data_i = '0;
    b1.wr_strb_i = '0;
    b3.rd_req_i  = 1'b0;
    b3.rd_addr_i = '0;
    b3.wr_req_i  = 1'b0;
    b3.wr_addr_i = '0;
    b3.wr_data_i = '0;
    b3.wr_strb_i = '0;
    test_reset();
    test_read();
    test_write();
    test_tie();
    test_back_to_back();
    test_lat3();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
